// File: rtl/result_accumulator_pkg.sv
// result_accumulator_pkg
// Shared state type, default widths and the lane arithmetic helpers used by
// the result accumulator and its per-lane adder (acc_lane).
package result_accumulator_pkg;

    localparam int DEF_MATRIX_SIZE    = 16;
    localparam int DEF_PARTIAL_SUM_BW = 24;
    localparam int DEF_ACC_BW         = 32;
    localparam int DEF_DEPTH          = 16;

    // Working width of the lane helpers; ACC_BW must stay below it so that a
    // single addition can never overflow the working value itself.
    localparam int WORK_BW = 64;

    typedef logic [WORK_BW-1:0] work_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } acc_state_e;

    // Replicate bit (from_bw-1) of val into every bit above it.
    function automatic work_t sign_extend(input work_t val, input int from_bw);
        return work_t'($signed(val << (WORK_BW - from_bw)) >>> (WORK_BW - from_bw));
    endfunction

    // Add two sign-extended operands; with sat set, clamp the sum to the
    // signed range of a bw-bit value. Without sat the caller truncates to bw
    // bits, which gives wrap-around modulo 2^bw.
    function automatic work_t lane_add(input work_t a, input work_t b,
                                       input int bw, input logic sat);
        work_t one;
        work_t sum;
        work_t max_v;
        work_t min_v;
        one   = work_t'(1);
        sum   = a + b;
        max_v = (one << (bw - 1)) - one;
        min_v = ~max_v;
        if (sat) begin
            if ($signed(sum) > $signed(max_v)) begin
                sum = max_v;
            end else if ($signed(sum) < $signed(min_v)) begin
                sum = min_v;
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/result_accumulator_lane.sv
// acc_lane
// Single result lane: either overwrites with the sign-extended partial sum
// (first tile) or adds it to the stored accumulator value.
// Macro RESULT_ACC_SAT_EN: when defined the addition saturates to the signed
// ACC_BW range, otherwise it wraps modulo 2^ACC_BW.
module acc_lane
    import result_accumulator_pkg::*;
#(
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int ACC_BW         = DEF_ACC_BW
) (
    input  logic [PARTIAL_SUM_BW-1:0] partial_i,
    input  logic [ACC_BW-1:0]         stored_i,
    input  logic                      overwrite_i,
    output logic [ACC_BW-1:0]         result_o
);

`ifdef RESULT_ACC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    work_t partial_ext;
    work_t stored_ext;

    // Widen both operands, then pick overwrite or (wrapping/saturating) sum.
    always_comb begin
        partial_ext = sign_extend(work_t'(partial_i), PARTIAL_SUM_BW);
        stored_ext  = sign_extend(work_t'(stored_i), ACC_BW);
        result_o    = overwrite_i ? ACC_BW'(partial_ext)
                                  : ACC_BW'(lane_add(stored_ext, partial_ext, ACC_BW, SAT_EN));
    end

endmodule

// File: rtl/result_accumulator.sv
// result_accumulator
// Accumulates num_tiles tiles of DEPTH result rows into a row buffer, then
// drains the buffer row by row over a valid/ready interface.
// Macro RESULT_ACC_SAT_EN: saturating lane addition instead of wrap-around.
module result_accumulator
    import result_accumulator_pkg::*;
#(
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int PARTIAL_SUM_BW = DEF_PARTIAL_SUM_BW,
    parameter int ACC_BW         = DEF_ACC_BW,
    parameter int DEPTH          = DEF_DEPTH,
    localparam int ADDR_BW       = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    input  logic [7:0]                         num_tiles,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ACC_BW*MATRIX_SIZE-1:0]      out_data,
    output logic [ADDR_BW-1:0]                 out_addr,
    output logic                               busy,
    output logic                               done
);

    localparam logic [ADDR_BW-1:0] LAST_ROW = ADDR_BW'(DEPTH - 1);
    localparam logic [ADDR_BW-1:0] ADDR_ONE = ADDR_BW'(1);

    acc_state_e         state_q, state_d;
    logic [ADDR_BW-1:0] row_ptr_q, row_ptr_d;
    logic [ADDR_BW-1:0] out_addr_q, out_addr_d;
    logic [7:0]         tile_cnt_q, tile_cnt_d;
    logic [7:0]         num_tiles_q, num_tiles_d;

    logic [ACC_BW-1:0]  buf_q [DEPTH][MATRIX_SIZE];
    logic [ACC_BW-1:0]  lane_result [MATRIX_SIZE];
    logic               row_accept;

    assign row_accept = (state_q == ACCUM) && in_valid;

    for (genvar l = 0; l < MATRIX_SIZE; l++) begin : g_lane
        acc_lane #(
            .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
            .ACC_BW        (ACC_BW)
        ) u_lane (
            .partial_i  (in_data[l*PARTIAL_SUM_BW +: PARTIAL_SUM_BW]),
            .stored_i   (buf_q[row_ptr_q][l]),
            .overwrite_i(tile_cnt_q == 8'd0),
            .result_o   (lane_result[l])
        );
        assign out_data[l*ACC_BW +: ACC_BW] = buf_q[out_addr_q][l];
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out_addr  = out_addr_q;

    // Row buffer has no reset: the first tile of every job overwrites it.
    always_ff @(posedge clk) begin
        if (row_accept) begin
            for (int l = 0; l < MATRIX_SIZE; l++) begin
                buf_q[row_ptr_q][l] <= lane_result[l];
            end
        end
    end

    // Control registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            row_ptr_q   <= '0;
            out_addr_q  <= '0;
            tile_cnt_q  <= '0;
            num_tiles_q <= 8'd1;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            out_addr_q  <= out_addr_d;
            tile_cnt_q  <= tile_cnt_d;
            num_tiles_q <= num_tiles_d;
        end
    end

    // Next-state logic: job start, row/tile counting, drain sequencing.
    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        out_addr_d  = out_addr_q;
        tile_cnt_d  = tile_cnt_q;
        num_tiles_d = num_tiles_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = ACCUM;
                    num_tiles_d = (num_tiles == 8'd0) ? 8'd1 : num_tiles;
                    row_ptr_d   = '0;
                    tile_cnt_d  = '0;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (row_ptr_q == LAST_ROW) begin
                        row_ptr_d  = '0;
                        tile_cnt_d = tile_cnt_q + 8'd1;
                        if (tile_cnt_q == num_tiles_q - 8'd1) begin
                            state_d    = DRAIN;
                            out_addr_d = '0;
                        end
                    end else begin
                        row_ptr_d = row_ptr_q + ADDR_ONE;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (out_addr_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        out_addr_d = out_addr_q + ADDR_ONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_accumulator.sv
// tb_result_accumulator
// Table of accumulation jobs driven into the default-size accumulator and
// checked against a per-row arithmetic model, plus hand-written sequences for
// mid-job reset and lane overflow on a small 24-bit instance.
// Honours RESULT_ACC_SAT_EN for the expected overflow behaviour.
module tb_result_accumulator;

    localparam int MS    = 16;
    localparam int PSB   = 24;
    localparam int ACC   = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam longint ACC_MAX = (longint'(1) <<< (ACC - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC - 1));

    typedef struct {
        logic [7:0] num_tiles;
        int         data_mode;
        int         gap_pct;
        int         bp_mode;
        bit         poke_start;
        bit         poke_drain;
        bit         has_exp;
        int         exp_mul;
        int         exp_add;
    } job_t;

    logic                clk = 1'b0;
    logic                rstn;
    logic                start;
    logic [7:0]          num_tiles;
    logic                in_valid;
    logic                in_ready;
    logic [MS*PSB-1:0]   in_data;
    logic                out_valid;
    logic                out_ready;
    logic [MS*ACC-1:0]   out_data;
    logic [AW-1:0]       out_addr;
    logic                busy;
    logic                done;

    logic                o_start;
    logic [7:0]          o_num_tiles;
    logic                o_in_valid;
    logic                o_in_ready;
    logic [47:0]         o_in_data;
    logic                o_out_valid;
    logic                o_out_ready;
    logic [47:0]         o_out_data;
    logic [0:0]          o_out_addr;
    logic                o_busy;
    logic                o_done;

    int vectors = 0;
    int miscompares = 0;
    int exp_buf [DEPTH][MS];
    job_t jobs [8];

    always #5 clk = ~clk;

    result_accumulator #(
        .MATRIX_SIZE(MS), .PARTIAL_SUM_BW(PSB), .ACC_BW(ACC), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_tiles(num_tiles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done)
    );

    result_accumulator #(
        .MATRIX_SIZE(2), .PARTIAL_SUM_BW(24), .ACC_BW(24), .DEPTH(2)
    ) dut_ovf (
        .clk(clk), .rstn(rstn), .start(o_start), .num_tiles(o_num_tiles),
        .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data),
        .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data),
        .out_addr(o_out_addr), .busy(o_busy), .done(o_done)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic checkRow(input string name, input logic [MS*ACC-1:0] actual,
                            input logic [MS*ACC-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Reference lane behaviour: first tile loads the sign-extended value,
    // later tiles add it with wrap or clamp to the 32-bit signed range.
    function automatic int modelAdd(input int stored, input logic [PSB-1:0] p, input bit first);
        longint s;
        s = longint'($signed(p));
        if (first) return int'(s);
        s = longint'(stored) + s;
`ifdef RESULT_ACC_SAT_EN
        if (s > ACC_MAX) s = ACC_MAX;
        if (s < ACC_MIN) s = ACC_MIN;
`endif
        return int'(s);
    endfunction

    function automatic logic [MS*PSB-1:0] rowData(input int mode, input int t, input int r);
        logic [MS*PSB-1:0] v;
        for (int l = 0; l < MS; l++) begin
            case (mode)
                0:       v[l*PSB +: PSB] = PSB'(r);
                1:       v[l*PSB +: PSB] = PSB'(-5);
                2:       v[l*PSB +: PSB] = PSB'($urandom);
                default: v[l*PSB +: PSB] = PSB'(t * 100 + r * 7 - l * 13);
            endcase
        end
        return v;
    endfunction

    function automatic logic [MS*ACC-1:0] expectedRow(input job_t j, input int r);
        logic [MS*ACC-1:0] v;
        for (int l = 0; l < MS; l++) begin
            v[l*ACC +: ACC] = j.has_exp ? ACC'(j.exp_mul * r + j.exp_add) : ACC'(exp_buf[r][l]);
        end
        return v;
    endfunction

    task automatic resetDut();
        @(negedge clk);
        rstn = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One complete job: start, feed all tiles with optional gaps, drain with
    // the selected backpressure pattern, then check the done pulse.
    task automatic applyStimulus(input job_t j);
        int tiles;
        int got;
        bit accepted;
        bit stalled;
        logic [MS*PSB-1:0] row;
        logic [MS*ACC-1:0] held_data;
        logic [AW-1:0] held_addr;
        tiles = (j.num_tiles == 8'd0) ? 1 : int'(j.num_tiles);
        @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("idle_in_ready", 64'(in_ready), 64'(0));
        start = 1'b1;
        num_tiles = j.num_tiles;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        for (int t = 0; t < tiles; t++) begin
            for (int r = 0; r < DEPTH; r++) begin
                row = rowData(j.data_mode, t, r);
                accepted = 1'b0;
                for (int w = 0; w < 200 && !accepted; w++) begin
                    start = j.poke_start && t == 0 && r == 3 && w == 0;
                    num_tiles = start ? 8'd200 : 8'($urandom);
                    if ($urandom_range(99) < j.gap_pct) begin
                        in_valid = 1'b0;
                        in_data = rowData(2, 0, 0);
                    end else begin
                        in_valid = 1'b1;
                        in_data = row;
                        if (in_ready) begin
                            accepted = 1'b1;
                            for (int l = 0; l < MS; l++) begin
                                exp_buf[r][l] = modelAdd(exp_buf[r][l], row[l*PSB +: PSB], t == 0);
                            end
                        end
                    end
                    @(negedge clk);
                end
                start = 1'b0;
                if (!accepted) begin
                    checkOutput("in_ready_timeout", 64'(0), 64'(1));
                    resetDut();
                    return;
                end
            end
        end
        in_valid = j.poke_drain;
        in_data = rowData(2, 0, 0);
        checkOutput("in_ready_drain", 64'(in_ready), 64'(0));
        checkOutput("drain_addr0", 64'(out_addr), 64'(0));
        got = 0;
        stalled = 1'b0;
        held_data = '0;
        held_addr = '0;
        for (int c = 0; c < 300 && got < DEPTH; c++) begin
            case (j.bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 2 == 0);
                default: out_ready = 1'($urandom_range(1));
            endcase
            start = j.poke_start && c == 2;
            if (j.poke_drain) begin
                in_data = rowData(2, 0, 0);
                checkOutput("in_ready_poke", 64'(in_ready), 64'(0));
            end
            if (stalled) begin
                checkRow("stall_data", out_data, held_data);
                checkOutput("stall_addr", 64'(out_addr), 64'(held_addr));
            end
            checkOutput("out_valid", 64'(out_valid), 64'(1));
            if (out_ready) begin
                checkOutput("out_addr", 64'(out_addr), 64'(got));
                checkRow("out_data", out_data, expectedRow(j, got));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_data = out_data;
                held_addr = out_addr;
            end
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (got < DEPTH) begin
            checkOutput("drain_timeout", 64'(got), 64'(DEPTH));
            resetDut();
            return;
        end
        checkOutput("done_pulse", 64'(done), 64'(1));
        checkOutput("out_valid_done", 64'(out_valid), 64'(0));
        @(negedge clk);
        checkOutput("done_cleared", 64'(done), 64'(0));
        checkOutput("busy_cleared", 64'(busy), 64'(0));
    endtask

    // Two tiles of extreme values on the 24-bit instance: wrap or clamp.
    task automatic runOverflow();
        logic [23:0] exp0;
        logic [23:0] exp1;
        int got;
`ifdef RESULT_ACC_SAT_EN
        exp0 = 24'h7FFFFF;
        exp1 = 24'h800000;
`else
        exp0 = 24'hFFFFFE;
        exp1 = 24'h000000;
`endif
        @(negedge clk);
        o_start = 1'b1;
        o_num_tiles = 8'd2;
        @(negedge clk);
        o_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("ovf_in_ready", 64'(o_in_ready), 64'(1));
            o_in_valid = 1'b1;
            o_in_data = {24'h800000, 24'h7FFFFF};
            @(negedge clk);
        end
        o_in_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < 2; c++) begin
            o_out_ready = 1'b1;
            if (o_out_valid) begin
                checkOutput("ovf_addr", 64'(o_out_addr), 64'(got));
                checkOutput("ovf_lane0", 64'(o_out_data[23:0]), 64'(exp0));
                checkOutput("ovf_lane1", 64'(o_out_data[47:24]), 64'(exp1));
                got++;
            end
            @(negedge clk);
        end
        o_out_ready = 1'b0;
        checkOutput("ovf_rows", 64'(got), 64'(2));
        checkOutput("ovf_done", 64'(o_done), 64'(1));
        @(negedge clk);
        checkOutput("ovf_idle", 64'(o_busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        jobs[0] = '{num_tiles: 8'd1, data_mode: 0, gap_pct: 0,  bp_mode: 0, poke_start: 1'b0, poke_drain: 1'b0, has_exp: 1'b1, exp_mul: 1, exp_add: 0};
        jobs[1] = '{num_tiles: 8'd3, data_mode: 1, gap_pct: 0,  bp_mode: 1, poke_start: 1'b0, poke_drain: 1'b0, has_exp: 1'b1, exp_mul: 0, exp_add: -15};
        jobs[2] = '{num_tiles: 8'd0, data_mode: 0, gap_pct: 0,  bp_mode: 0, poke_start: 1'b0, poke_drain: 1'b1, has_exp: 1'b1, exp_mul: 1, exp_add: 0};
        jobs[3] = '{num_tiles: 8'd2, data_mode: 0, gap_pct: 10, bp_mode: 1, poke_start: 1'b1, poke_drain: 1'b0, has_exp: 1'b1, exp_mul: 2, exp_add: 0};
        jobs[4] = '{num_tiles: 8'd2, data_mode: 2, gap_pct: 30, bp_mode: 2, poke_start: 1'b1, poke_drain: 1'b0, has_exp: 1'b0, exp_mul: 0, exp_add: 0};
        jobs[5] = '{num_tiles: 8'd4, data_mode: 3, gap_pct: 20, bp_mode: 1, poke_start: 1'b1, poke_drain: 1'b1, has_exp: 1'b0, exp_mul: 0, exp_add: 0};
        jobs[6] = '{num_tiles: 8'd1, data_mode: 2, gap_pct: 0,  bp_mode: 2, poke_start: 1'b0, poke_drain: 1'b1, has_exp: 1'b0, exp_mul: 0, exp_add: 0};
        jobs[7] = '{num_tiles: 8'd5, data_mode: 2, gap_pct: 40, bp_mode: 2, poke_start: 1'b1, poke_drain: 1'b0, has_exp: 1'b0, exp_mul: 0, exp_add: 0};

        rstn = 1'b0;
        start = 1'b0;
        num_tiles = 8'd0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        o_start = 1'b0;
        o_num_tiles = 8'd0;
        o_in_valid = 1'b0;
        o_in_data = '0;
        o_out_ready = 1'b0;
        #1;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_in_ready", 64'(in_ready), 64'(0));
        checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_out_addr", 64'(out_addr), 64'(0));
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(jobs[i]);
        end

        // Abort a three-tile job at row 7 of tile 1, then run a fresh job.
        @(negedge clk);
        start = 1'b1;
        num_tiles = 8'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DEPTH + 7; i++) begin
            in_valid = 1'b1;
            in_data = rowData(3, i / DEPTH, i % DEPTH);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkOutput("abort_busy_before", 64'(busy), 64'(1));
        rstn = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_in_ready", 64'(in_ready), 64'(0));
        checkOutput("abort_out_valid", 64'(out_valid), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_out_addr", 64'(out_addr), 64'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        applyStimulus(jobs[6]);
        applyStimulus(jobs[0]);

        runOverflow();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
